fpu_ss_compressed_arbiter: RTL and testbench

Sequential front-end for the FPU subsystem's compressed-instruction predecoder. Several requesters, such as per-hart offload ports, share one predecoder instance. This block arbitrates among them round-robin, registers the selected 16-bit instruction, and drives the predecoder from that register. It then registers the predecoder result and holds it on a valid/ready response channel until the granted requester consumes it. It also keeps a saturating count of rejected (non-FP) compressed instructions.

---
 rtl/fpu_ss_compressed_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_fpu_ss_compressed_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_compressed_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_ss_compressed_pkg / fpu_ss_compressed_arbiter
//
// Purpose: shares one compressed-instruction predecoder among NUM_REQ
// requesters. A round-robin arbiter picks one request and registers its
// 16-bit instruction. The predecoder is driven from that register for one
// cycle. Its result is registered and held on a per-requester valid/ready
// response channel until the granted requester takes it. Compressed
// instructions that the predecoder does not accept (non-FP) are counted in
// a saturating counter.
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-high reset
//   flush_i       synchronous kill of any in-flight request
//   req_valid_i   per-requester request valid             [NUM_REQ]
//   req_ready_o   per-requester request ready, one-hot/0  [NUM_REQ]
//   req_instr_i   packed 16-bit instructions              [NUM_REQ*16]
//   rsp_valid_o   response valid to granted requester     [NUM_REQ]
//   rsp_ready_i   per-requester response ready            [NUM_REQ]
//   rsp_instr_o   decompressed instruction                [32]
//   rsp_accept_o  instruction is an FP compressed load/store
//   prd_req_o     request to the predecoder
//   prd_rsp_i     combinational answer from the predecoder
//   reject_cnt_o  saturating count of accept=0 results    [CNT_WIDTH]
// ---------------------------------------------------------------------------
package fpu_ss_compressed_pkg;

  typedef struct packed {
    logic [31:0] comp_instr;
    logic [1:0]  mode;
  } comp_prd_req_t;

  typedef struct packed {
    logic        accept;
    logic [31:0] decomp_instr;
  } comp_prd_rsp_t;

endpackage

module fpu_ss_compressed_arbiter
  import fpu_ss_compressed_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*16-1:0]   req_instr_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  input  logic [NUM_REQ-1:0]      rsp_ready_i,
  output logic [31:0]             rsp_instr_o,
  output logic                    rsp_accept_o,
  output comp_prd_req_t           prd_req_o,
  input  comp_prd_rsp_t           prd_rsp_i,
  output logic [CNT_WIDTH-1:0]    reject_cnt_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PREDECODE = 2'd1,
    RESPOND   = 2'd2
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_q;
  logic [IDX_W-1:0]     grant_q;
  logic [15:0]          comp_q;
  logic [31:0]          instr_q;
  logic                 acc_q;
  logic [CNT_WIDTH-1:0] reject_cnt_q;

  logic [IDX_W-1:0]     grant;
  logic                 grant_found;
  logic [IDX_W:0]       search_sum;
  logic [IDX_W-1:0]     search_idx;
  logic [IDX_W-1:0]     rr_next;

  // Round-robin search: walk indices starting at rr_q and wrap at NUM_REQ.
  // The sum is one bit wider than an index so the wrap compare cannot overflow.
  always_comb begin
    grant       = rr_q;
    grant_found = 1'b0;
    search_sum  = '0;
    search_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      search_sum = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (search_sum >= (IDX_W+1)'(NUM_REQ)) begin
        search_sum = search_sum - (IDX_W+1)'(NUM_REQ);
      end
      search_idx = search_sum[IDX_W-1:0];
      if (!grant_found && req_valid_i[search_idx]) begin
        grant       = search_idx;
        grant_found = 1'b1;
      end
    end
  end

  // The requester after the one just served gets first pick next time.
  assign rr_next = (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;

  // Request ready is the only combinational input-to-output path. It is
  // gated with reset so every output reads zero while reset is held.
  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && !flush_i && !rst_i && grant_found) begin
      req_ready_o[grant] = 1'b1;
    end
  end

  // Outputs toward the predecoder and the responders decode registers only,
  // so nothing from req_* or prd_rsp_i reaches them in the same cycle.
  always_comb begin
    prd_req_o    = '0;
    rsp_valid_o  = '0;
    rsp_instr_o  = '0;
    rsp_accept_o = 1'b0;
    if (state_q == PREDECODE) begin
      prd_req_o.comp_instr = {16'h0000, comp_q};
    end
    if (state_q == RESPOND) begin
      rsp_valid_o[grant_q] = 1'b1;
      rsp_instr_o          = instr_q;
      rsp_accept_o         = acc_q;
    end
  end

  assign reject_cnt_o = reject_cnt_q;

  // Main control FSM. A flush during PREDECODE discards the predecoder
  // result without counting it. A flush during RESPOND drops the held
  // result unless the response handshake completes in the same cycle.
  // rr_q only advances on a completed response, so a flushed requester
  // keeps its priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      grant_q      <= '0;
      comp_q       <= '0;
      instr_q      <= '0;
      acc_q        <= 1'b0;
      reject_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!flush_i && grant_found) begin
            comp_q  <= req_instr_i[{grant, 4'b0000} +: 16];
            grant_q <= grant;
            state_q <= PREDECODE;
          end
        end
        PREDECODE: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            instr_q <= prd_rsp_i.decomp_instr;
            acc_q   <= prd_rsp_i.accept;
            if (!prd_rsp_i.accept && reject_cnt_q != {CNT_WIDTH{1'b1}}) begin
              reject_cnt_q <= reject_cnt_q + 1'b1;
            end
            state_q <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready_i[grant_q]) begin
            rr_q    <= rr_next;
            state_q <= IDLE;
          end else if (flush_i) begin
            instr_q <= '0;
            acc_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_ss_compressed_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_ss_compressed_arbiter
//
// Self-checking bench for fpu_ss_compressed_arbiter. Two instances share all
// stimulus: one with the default 16-bit reject counter and one with a 2-bit
// counter so saturation is visible. A small behavioural predecoder answers
// both instances. A transaction-level model (one in-flight request with an
// age, a round-robin pointer and counters) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_fpu_ss_compressed_arbiter;
  import fpu_ss_compressed_pkg::*;

  localparam int N = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [N-1:0]     req_valid;
  logic [N*16-1:0]  req_instr;
  logic [N-1:0]     rsp_ready;

  logic [N-1:0]     req_ready, s_req_ready;
  logic [N-1:0]     rsp_valid, s_rsp_valid;
  logic [31:0]      rsp_instr, s_rsp_instr;
  logic             rsp_accept, s_rsp_accept;
  comp_prd_req_t    prd_req, s_prd_req;
  comp_prd_rsp_t    prd_rsp, s_prd_rsp;
  logic [15:0]      reject_cnt;
  logic [1:0]       s_reject_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state: one request in flight, aged 1 in PREDECODE and 2+
  // while its response is offered.
  int          m_rr = 0;
  bit          m_busy = 1'b0;
  int          m_age = 0;
  int          m_owner = 0;
  logic [15:0] m_held = '0;
  int          m_cnt16 = 0;
  int          m_cnt2 = 0;

  typedef struct {
    logic [15:0] instr;
    int          req;
    logic [31:0] exp_instr;
    logic        exp_accept;
  } vec_t;

  fpu_ss_compressed_arbiter #(.NUM_REQ(N), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_instr_i(req_instr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_instr_o(rsp_instr), .rsp_accept_o(rsp_accept),
    .prd_req_o(prd_req), .prd_rsp_i(prd_rsp), .reject_cnt_o(reject_cnt)
  );

  fpu_ss_compressed_arbiter #(.NUM_REQ(N), .CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(s_req_ready), .req_instr_i(req_instr),
    .rsp_valid_o(s_rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_instr_o(s_rsp_instr), .rsp_accept_o(s_rsp_accept),
    .prd_req_o(s_prd_req), .prd_rsp_i(s_prd_rsp), .reject_cnt_o(s_reject_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural predecoder: quadrant-0 FP loads/stores (C.FLW, C.FLD, C.FSW,
  // C.FSD) expand to their 32-bit forms; anything else is rejected with 0.
  function automatic comp_prd_rsp_t predec(input logic [15:0] c);
    comp_prd_rsp_t r;
    logic [11:0]   imm_w;
    logic [11:0]   imm_d;
    r     = '0;
    imm_w = {5'b0, c[5], c[12:10], c[6], 2'b00};
    imm_d = {4'b0, c[6:5], c[12:10], 3'b000};
    case ({c[15:13], c[1:0]})
      5'b011_00: begin
        r.decomp_instr = {imm_w, 2'b01, c[9:7], 3'b010, 2'b01, c[4:2], 7'b0000111};
        r.accept = 1'b1;
      end
      5'b001_00: begin
        r.decomp_instr = {imm_d, 2'b01, c[9:7], 3'b011, 2'b01, c[4:2], 7'b0000111};
        r.accept = 1'b1;
      end
      5'b111_00: begin
        r.decomp_instr = {imm_w[11:5], 2'b01, c[4:2], 2'b01, c[9:7], 3'b010, imm_w[4:0], 7'b0100111};
        r.accept = 1'b1;
      end
      5'b101_00: begin
        r.decomp_instr = {imm_d[11:5], 2'b01, c[4:2], 2'b01, c[9:7], 3'b011, imm_d[4:0], 7'b0100111};
        r.accept = 1'b1;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb prd_rsp   = predec(prd_req.comp_instr[15:0]);
  always_comb s_prd_rsp = predec(s_prd_req.comp_instr[15:0]);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives inputs just after the active edge and lets combinational outputs settle.
  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N*16-1:0] instr,
                               input logic [N-1:0] ready, input logic fl);
    req_valid = valid;
    req_instr = instr;
    rsp_ready = ready;
    flush     = fl;
    #1;
  endtask

  // Compares both instances against the model at the falling edge, then
  // advances the model across the next rising edge.
  task automatic runClock();
    logic [N-1:0]  e_ready;
    logic [N-1:0]  e_valid;
    logic [31:0]   e_instr;
    logic          e_acc;
    comp_prd_req_t e_prd;
    comp_prd_rsp_t d;
    int            g;
    int            idx;
    @(negedge clk);
    e_ready = '0;
    e_valid = '0;
    e_instr = '0;
    e_acc   = 1'b0;
    e_prd   = '0;
    g       = -1;
    if (!m_busy) begin
      if (!flush) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) e_ready[g] = 1'b1;
    end else if (m_age == 1) begin
      e_prd.comp_instr = {16'h0000, m_held};
    end else begin
      d = predec(m_held);
      e_valid[m_owner] = 1'b1;
      e_instr = d.decomp_instr;
      e_acc   = d.accept;
    end
    checkOutput("req_ready", 64'(req_ready), 64'(e_ready));
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(e_valid));
    checkOutput("rsp_instr", 64'(rsp_instr), 64'(e_instr));
    checkOutput("rsp_accept", 64'(rsp_accept), 64'(e_acc));
    checkOutput("prd_req", 64'(prd_req), 64'(e_prd));
    checkOutput("reject_cnt", 64'(reject_cnt), 64'(m_cnt16));
    checkOutput("sat_rsp_valid", 64'(s_rsp_valid), 64'(e_valid));
    checkOutput("sat_reject_cnt", 64'(s_reject_cnt), 64'(m_cnt2));
    if (!m_busy) begin
      if (g >= 0) begin
        m_busy  = 1'b1;
        m_age   = 1;
        m_owner = g;
        m_held  = req_instr[16*g +: 16];
      end
    end else if (m_age == 1) begin
      if (flush) begin
        m_busy = 1'b0;
      end else begin
        m_age = 2;
        d = predec(m_held);
        if (!d.accept) begin
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
    end else begin
      if (rsp_ready[m_owner]) begin
        m_rr   = (m_owner + 1) % N;
        m_busy = 1'b0;
      end else if (flush) begin
        m_busy = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*16-1:0] place(input int req, input logic [15:0] instr);
    logic [N*16-1:0] v;
    v = '0;
    v[16*req +: 16] = instr;
    return v;
  endfunction

  // One complete transaction from a single requester with response ready.
  task automatic oneTxn(input int req, input logic [15:0] instr);
    logic [N-1:0] oh;
    oh = '0;
    oh[req] = 1'b1;
    applyStimulus(oh, place(req, instr), '0, 1'b0);
    runClock();
    applyStimulus('0, '0, '0, 1'b0);
    runClock();
    applyStimulus('0, '0, oh, 1'b0);
    runClock();
  endtask

  // Takes a request into RESPOND, raises reset mid-cycle and expects every
  // output to drop at once, then checks no stale response appears.
  task automatic midReset();
    applyStimulus(2'b01, place(0, 16'h0001), '0, 1'b0);
    runClock();
    applyStimulus('0, '0, '0, 1'b0);
    runClock();
    checkOutput("pre_rst_valid", 64'(rsp_valid), 64'(2'b01));
    applyStimulus(2'b11, place(0, 16'h6000), '0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("rst_rsp_instr", 64'(rsp_instr), 64'h0);
    checkOutput("rst_rsp_accept", 64'(rsp_accept), 64'h0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'h0);
    checkOutput("rst_prd_req", 64'(prd_req), 64'h0);
    checkOutput("rst_cnt", 64'(reject_cnt), 64'h0);
    checkOutput("rst_sat_cnt", 64'(s_reject_cnt), 64'h0);
    m_rr = 0; m_busy = 1'b0; m_age = 0; m_owner = 0; m_held = '0;
    m_cnt16 = 0; m_cnt2 = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    applyStimulus('0, '0, 2'b11, 1'b0);
    rst = 1'b0;
    repeat (4) runClock();
  endtask

  initial begin
    vec_t         vecs[6];
    int           grant_cycle[$];
    int           grant_idx[$];
    int           cnt_before;
    logic [15:0]  r16;
    logic [N-1:0] rv;
    int           sat_exp[5];

    vecs[0] = '{16'h6000, 0, 32'h00042407, 1'b1};
    vecs[1] = '{16'h0001, 1, 32'h00000000, 1'b0};
    vecs[2] = '{16'hE000, 1, 32'h00842027, 1'b1};
    vecs[3] = '{16'h2000, 0, 32'h00043407, 1'b1};
    vecs[4] = '{16'h6404, 1, 32'h00842487, 1'b1};
    vecs[5] = '{16'h4000, 0, 32'h00000000, 1'b0};

    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 2'b11;
    req_instr = {16'h6000, 16'h6000};
    rsp_ready = 2'b11;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", 64'(req_ready), 64'h0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("reset_rsp_instr", 64'(rsp_instr), 64'h0);
    checkOutput("reset_prd_req", 64'(prd_req), 64'h0);
    checkOutput("reset_cnt", 64'(reject_cnt), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus('0, '0, '0, 1'b0);
    runClock();

    // Table: each vector as one transaction with a fixed two-cycle latency.
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] oh;
      oh = '0;
      oh[vecs[i].req] = 1'b1;
      applyStimulus(oh, place(vecs[i].req, vecs[i].instr), '0, 1'b0);
      checkOutput("tbl_req_ready", 64'(req_ready), 64'(oh));
      runClock();
      applyStimulus('0, '0, '0, 1'b0);
      checkOutput("tbl_no_early_rsp", 64'(rsp_valid), 64'h0);
      runClock();
      applyStimulus('0, '0, oh, 1'b0);
      checkOutput("tbl_rsp_valid", 64'(rsp_valid), 64'(oh));
      checkOutput("tbl_rsp_instr", 64'(rsp_instr), 64'(vecs[i].exp_instr));
      checkOutput("tbl_rsp_accept", 64'(rsp_accept), 64'(vecs[i].exp_accept));
      runClock();
      checkOutput("tbl_back_idle", 64'(rsp_valid), 64'h0);
    end
    checkOutput("tbl_reject_cnt", 64'(reject_cnt), 64'd2);

    // Fairness: both requesters always valid, responses always taken.
    for (int c = 0; c < 12; c++) begin
      applyStimulus(2'b11, {16'hE000, 16'h6000}, 2'b11, 1'b0);
      if (req_ready != '0) begin
        grant_cycle.push_back(c);
        grant_idx.push_back(req_ready[1] ? 1 : 0);
      end
      runClock();
    end
    checkOutput("fair_grant_count", 64'(grant_cycle.size()), 64'd4);
    for (int k = 1; k < grant_cycle.size(); k++) begin
      checkOutput("fair_alternate", 64'(grant_idx[k] != grant_idx[k-1]), 64'd1);
      checkOutput("fair_spacing", 64'(grant_cycle[k] - grant_cycle[k-1]), 64'd3);
    end

    // Backpressure: response held for 5 cycles, other requester waiting.
    applyStimulus('0, '0, '0, 1'b0);
    repeat (3) runClock();
    applyStimulus(2'b01, place(0, 16'h6404), '0, 1'b0);
    runClock();
    applyStimulus(2'b10, place(1, 16'h6000), 2'b10, 1'b0);
    runClock();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(2'b10, place(1, 16'h6000), 2'b10, 1'b0);
      checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'(2'b01));
      checkOutput("bp_rsp_instr", 64'(rsp_instr), 64'h00842487);
      checkOutput("bp_req_ready", 64'(req_ready), 64'h0);
      runClock();
    end
    applyStimulus('0, '0, 2'b01, 1'b0);
    runClock();

    // Flush in PREDECODE: no response, counter unchanged, same requester next.
    cnt_before = int'(reject_cnt);
    applyStimulus(2'b11, {16'h0001, 16'h6000}, '0, 1'b0);
    checkOutput("fl_first_grant", 64'(req_ready), 64'(2'b10));
    runClock();
    applyStimulus('0, '0, 2'b11, 1'b1);
    runClock();
    applyStimulus('0, '0, 2'b11, 1'b0);
    checkOutput("fl_no_rsp", 64'(rsp_valid), 64'h0);
    runClock();
    checkOutput("fl_cnt_same", 64'(reject_cnt), 64'(cnt_before));
    applyStimulus(2'b11, {16'h0001, 16'h6000}, '0, 1'b0);
    checkOutput("fl_regrant", 64'(req_ready), 64'(2'b10));
    runClock();
    applyStimulus('0, '0, '0, 1'b0);
    runClock();
    // Flush in RESPOND without handshake drops the result.
    applyStimulus('0, '0, '0, 1'b1);
    checkOutput("fl_rsp_offered", 64'(rsp_valid), 64'(2'b10));
    runClock();
    applyStimulus(2'b11, {16'h0001, 16'h6000}, '0, 1'b0);
    checkOutput("fl_rsp_dropped", 64'(rsp_valid), 64'h0);
    checkOutput("fl_keeps_priority", 64'(req_ready), 64'(2'b10));
    runClock();
    applyStimulus('0, '0, '0, 1'b0);
    runClock();
    // Flush together with a handshake completes it and advances priority.
    applyStimulus('0, '0, 2'b10, 1'b1);
    runClock();
    applyStimulus(2'b11, {16'h0001, 16'h6000}, '0, 1'b0);
    checkOutput("fl_hs_advances", 64'(req_ready), 64'(2'b01));
    runClock();
    applyStimulus('0, '0, 2'b11, 1'b0);
    repeat (3) runClock();

    // Randomized traffic checked against the model.
    for (int c = 0; c < 400; c++) begin
      logic [N*16-1:0] ins;
      for (int k = 0; k < N; k++) begin
        r16 = 16'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          r16[1:0]   = 2'b00;
          r16[15:13] = 3'(2 * $urandom_range(0, 3) + 1);
        end
        ins[16*k +: 16] = r16;
      end
      rv = N'($urandom);
      applyStimulus(rv, ins, N'($urandom), ($urandom_range(0, 19) == 0));
      runClock();
    end

    // Reset in RESPOND, then saturation of the 2-bit counter.
    midReset();
    sat_exp = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 5; i++) begin
      oneTxn(i % N, 16'h0001);
      checkOutput("sat_cnt", 64'(s_reject_cnt), 64'(sat_exp[i]));
      checkOutput("wide_cnt", 64'(reject_cnt), 64'(i + 1));
    end
    midReset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
